muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative RV32M multiply/divide unit, the multi-cycle companion to the single-cycle ALU.
//   Accepts one request on a start pulse and holds off the datapath via busy.
//   Returns a 32-bit result with a one-cycle done pulse.
//   Sits beside the ALU in the execute stage; the datapath muxes Result into write-back.
// PARAMETERS
//   DATA_WIDTH   32  operand/result width; iteration count equals DATA_WIDTH
//   FUNCT3_WIDTH 3   width of the operation select (RV32M funct3)
// PORTS
//   clk      in   1           rising-edge clock
//   reset_n  in   1           asynchronous active-low reset
//   start    in   1           request strobe; sampled only in IDLE
//   flush    in   1           synchronous abort; returns to IDLE, no done
//   Funct3   in   3           000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   SrcA     in   DATA_WIDTH  rs1 operand (multiplicand / dividend)
//   SrcB     in   DATA_WIDTH  rs2 operand (multiplier / divisor)
//   busy     out  1           high from the cycle after start is accepted until done
//   done     out  1           one-cycle pulse; Result valid in the same cycle
//   Result   out  DATA_WIDTH  result; held stable until the next accepted start
// BEHAVIOUR
// - Reset (async, reset_n=0): state=IDLE, busy=0, done=0, Result=0, internal regs=0.
// - States: IDLE, CALC, DONE.
//   - IDLE & start: latch Funct3, operands and sign flags.
//     Divisor==0 on DIV/DIVU/REM/REMU -> DONE; else -> CALC, count=0.
//   - CALC: one iteration per cycle. At count==DATA_WIDTH-1 -> DONE.
//   - DONE: done=1, Result registered, busy=0; -> IDLE next cycle.
// - Latency: start at cycle 0 -> done at cycle DATA_WIDTH+1 (33). Divide-by-zero -> done at cycle 1.
// - Back-to-back: start is ignored in CALC/DONE. A new request is accepted the cycle after done.
// - flush (any state): -> IDLE, busy=0, done=0. Result keeps its previous value. flush beats start in the same cycle.
// - Multiply: shift-add on magnitudes into a 2*DATA_WIDTH product.
//   - Sign of SrcA used for MUL/MULH/MULHSU; sign of SrcB for MUL/MULH only.
//   - Product negated (two's complement, 64-bit) when the operand signs differ.
//   - MUL returns low half; MULH/MULHSU/MULHU return high half.
// - Divide: restoring, on magnitudes for DIV/REM (DIVU/REMU use raw operands).
//   - Quotient negated if the signs differ; remainder takes the sign of the dividend.
//   - Divide by zero: quotient = all ones, remainder = SrcA (no negation applied).
//   - Overflow 0x80000000 / -1: quotient 0x80000000, remainder 0. Falls out naturally from the 33-bit magnitude path; no special case.
// - All arithmetic is unsigned internally; signs are handled only in the pre/post conditioning.
// - Reset mid-CALC: immediate return to the reset values; the partial result is discarded.
// STRUCTURE
// - Shared package muldiv_pkg:
//   - typedef enum logic [2:0] funct3_e {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU}
//   - typedef enum logic [1:0] state_e {IDLE, CALC, DONE}
//   - localparam ITER = DATA_WIDTH
// - Sub-module muldiv_sign_fix (combinational):
//   - operand abs-value and sign-flag generation
//   - final negation/select of the result
// - muldiv_unit keeps the FSM, counter, and shared accumulator/shift registers.
// TESTING
// - MUL 7 * 0xFFFFFFFD(-3) -> Result 0xFFFFFFEB; done exactly 33 cycles after start; busy high cycles 1..32.
// - MULH 0x80000000*0x80000000 -> 0x40000000.
//   MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//   MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
// - DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD.
//   REM same operands -> 0xFFFFFFFF.
//   DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
//   REMU same operands -> 1.
// - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; done 1 cycle after start.
//   DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
// - start pulsed during CALC -> ignored; the original result is returned.
//   flush at cycle 10 -> busy=0, no done, Result unchanged.
// - reset_n low at cycle 15 of a DIV -> busy/done/Result 0 before the next edge; the next request completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int ITER = XLEN;

  typedef enum logic [2:0] {
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE, CALC, DONE
  } state_e;

  function automatic logic is_div(input funct3_e f);
    return f inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_rem(input funct3_e f);
    return f inside {REM, REMU};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign conditioning around the unsigned core: operand magnitudes and sign flags
// on the way in, negation and half/quotient/remainder selection on the way out.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  funct3_e        op_in,
  input  logic [W-1:0]   src_a,
  input  logic [W-1:0]   src_b,
  output logic [W-1:0]   mag_a,
  output logic [W-1:0]   mag_b,
  output logic           neg_res,
  output logic           div_zero,
  output logic [W-1:0]   zero_result,
  input  funct3_e        op_q,
  input  logic           neg_q,
  input  logic [2*W-1:0] acc,
  output logic [W-1:0]   result
);

  logic           sign_a;
  logic           sign_b;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;

  // NOTE: every output is assigned on every path (case has a default), so no latch is inferred.
  always_comb begin
    sign_a      = src_a[W-1] & (op_in inside {MUL, MULH, MULHSU, DIV, REM});
    sign_b      = src_b[W-1] & (op_in inside {MUL, MULH, DIV, REM});
    mag_a       = sign_a ? -src_a : src_a;
    mag_b       = sign_b ? -src_b : src_b;
    // A remainder follows the dividend; products and quotients follow the sign mismatch.
    neg_res     = is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
    div_zero    = is_div(op_in) && (src_b == '0);
    zero_result = is_rem(op_in) ? src_a : '1;

    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[W-1:0] : acc[W-1:0];
    rem  = neg_q ? -acc[2*W-1:W] : acc[2*W-1:W];

    case (op_q)
      MUL:                result = prod[W-1:0];
      MULH, MULHSU, MULHU: result = prod[2*W-1:W];
      DIV, DIVU:          result = quo;
      default:            result = rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per
// cycle on a shared 2*DATA_WIDTH accumulator, with a one-cycle done pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH   = ITER,
  parameter int FUNCT3_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    flush,
  input  logic [FUNCT3_WIDTH-1:0] Funct3,
  input  logic [DATA_WIDTH-1:0]   SrcA,
  input  logic [DATA_WIDTH-1:0]   SrcB,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   Result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  state_e         state;
  funct3_e        op_q;
  logic           neg_q;
  logic [CW-1:0]  count;
  logic [W-1:0]   opa_q;
  logic [W-1:0]   opb_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_next;

  funct3_e        op_in;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic           neg_res;
  logic           div_zero;
  logic [W-1:0]   zero_result;
  logic [W-1:0]   fix_result;

  logic [W:0]     add_sum;
  logic [W:0]     rem_shift;
  logic [W-1:0]   rem_diff;
  logic           rem_ge;

  assign op_in = funct3_e'(Funct3[2:0]);

  muldiv_sign_fix #(.W(W)) u_sign_fix (
    .op_in       (op_in),
    .src_a       (SrcA),
    .src_b       (SrcB),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .neg_res     (neg_res),
    .div_zero    (div_zero),
    .zero_result (zero_result),
    .op_q        (op_q),
    .neg_q       (neg_q),
    .acc         (acc_next),
    .result      (fix_result)
  );

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  // Divide:   acc = {partial remainder, dividend/quotient bits}, shifted left.
  always_comb begin
    add_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    rem_shift = acc_q[2*W-1:W-1];
    rem_ge    = (rem_shift >= {1'b0, opb_q});
    rem_diff  = rem_shift[W-1:0] - opb_q;
    if (is_div(op_q)) begin
      acc_next = {(rem_ge ? rem_diff : rem_shift[W-1:0]), acc_q[W-2:0], rem_ge};
    end else begin
      acc_next = {add_sum, acc_q[W-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= MUL;
      neg_q  <= 1'b0;
      count  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      acc_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op_in;
            neg_q <= neg_res;
            opa_q <= mag_a;
            opb_q <= mag_b;
            acc_q <= {{W{1'b0}}, (is_div(op_in) ? mag_a : mag_b)};
            count <= '0;
            if (div_zero) begin
              state  <= DONE;
              done   <= 1'b1;
              Result <= zero_result;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          acc_q <= acc_next;
          count <= count + CW'(1);
          if (count == CW'(W - 1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            Result <= fix_result;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// requests, compared every cycle against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic        pend = 1'b0;
  int          pend_start = 0;
  int          pend_lat = 0;
  int          pend_abort = 0;
  logic [31:0] pend_exp = 32'd0;
  logic [2:0]  pend_f = 3'd0;
  logic [31:0] pend_a = 32'd0;
  logic [31:0] pend_b = 32'd0;
  logic [31:0] held_result = 32'd0;

  muldiv_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .flush   (flush),
    .Funct3  (Funct3),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .busy    (busy),
    .done    (done),
    .Result  (Result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RV32M semantics straight from the ISA rules, using wide native arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      la;
    longint      lb;
    longint      lub;
    logic [63:0] p;
    sa  = a;
    sb  = b;
    la  = sa;
    lb  = sb;
    lub = {32'b0, b};
    p   = '0;
    case (f)
      3'd0: begin p = la * lb;  return p[31:0];  end
      3'd1: begin p = la * lb;  return p[63:32]; end
      3'd2: begin p = la * lub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 15));
      5: return 32'h0 - 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Single compare process: what busy/done/Result must be in this cycle.
  always @(negedge clk) begin : monitor
    logic exp_busy;
    logic exp_done;
    if (!reset_n) begin
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset Result", Result, 32'd0);
      held_result = 32'd0;
    end else begin
      exp_done = pend && (cyc == pend_start + pend_lat) && (cyc <= pend_abort);
      exp_busy = pend && (cyc > pend_start) && (cyc < pend_start + pend_lat) && (cyc <= pend_abort);
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      check("done", {31'b0, done}, {31'b0, exp_done});
      if (exp_done) begin
        check($sformatf("result f3=%0d a=%h b=%h", pend_f, pend_a, pend_b), Result, pend_exp);
        held_result = pend_exp;
      end else begin
        check("Result hold", Result, held_result);
      end
    end
  end

  // Called at posedge+1. Offsets count cycles after the start cycle; 0 means unused.
  task automatic run_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int ign_at, input int flush_at, input int rst_at);
    int off;
    int wait_end;
    Funct3     = f;
    SrcA       = a;
    SrcB       = b;
    start      = 1'b1;
    pend_f     = f;
    pend_a     = a;
    pend_b     = b;
    pend_exp   = model(f, a, b);
    pend_lat   = (f[2] && b == 0) ? 1 : 33;
    pend_start = cyc;
    pend_abort = (flush_at > 0) ? cyc + flush_at : cyc + 1000;
    pend       = 1'b1;
    wait_end   = (flush_at > 0) ? flush_at + 2 : pend_lat + 1;
    off        = 0;
    while (off < wait_end) begin
      @(posedge clk);
      #1;
      off    = cyc - pend_start;
      start  = (off == ign_at);
      flush  = (off == flush_at);
      Funct3 = 3'($urandom);
      SrcA   = $urandom;
      SrcB   = $urandom;
      if (off == rst_at) begin
        reset_n = 1'b0;
        pend    = 1'b0;
        start   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        off     = wait_end;
      end
    end
    start = 1'b0;
    flush = 1'b0;
    pend  = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    #1 reset_n = 1'b0;

    // Pin the model with hand-computed values.
    check("model MUL",    model(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    check("model MULH",   model(3'd1, 32'h80000000, 32'h80000000), 32'h40000000);
    check("model MULHSU", model(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    check("model MULHU",  model(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    check("model DIV",    model(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    check("model REM",    model(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
    check("model DIVU",   model(3'd5, 32'hFFFFFFF9, 32'd2), 32'h7FFFFFFC);
    check("model REMU",   model(3'd7, 32'hFFFFFFF9, 32'd2), 32'd1);
    check("model DIV0",   model(3'd4, 32'd5, 32'd0), 32'hFFFFFFFF);
    check("model REM0",   model(3'd6, 32'd5, 32'd0), 32'd5);
    check("model DIVOVF", model(3'd4, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    check("model REMOVF", model(3'd6, 32'h80000000, 32'hFFFFFFFF), 32'd0);

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_req(3'd0, 32'd7, 32'hFFFFFFFD, 0, 0, 0);
    run_req(3'd1, 32'h80000000, 32'h80000000, 0, 0, 0);
    run_req(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    run_req(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    run_req(3'd4, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
    run_req(3'd6, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
    run_req(3'd5, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
    run_req(3'd7, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
    run_req(3'd4, 32'd5, 32'd0, 0, 0, 0);
    run_req(3'd6, 32'd5, 32'd0, 0, 0, 0);
    run_req(3'd5, 32'hFFFFFFF0, 32'd0, 0, 0, 0);
    run_req(3'd7, 32'hFFFFFFF0, 32'd0, 0, 0, 0);
    run_req(3'd4, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
    run_req(3'd6, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);

    // start during CALC and during DONE must be ignored.
    run_req(3'd0, 32'd12345, 32'd678, 5, 0, 0);
    run_req(3'd4, 32'd9, 32'd0, 1, 0, 0);
    run_req(3'd1, 32'hDEADBEEF, 32'h12345678, 33, 0, 0);

    // flush mid-calculation, then a flush that coincides with start in IDLE.
    run_req(3'd0, 32'd3, 32'd4, 0, 10, 0);
    Funct3 = 3'd0;
    SrcA   = 32'd11;
    SrcB   = 32'd13;
    start  = 1'b1;
    flush  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a divide, then a clean request.
    run_req(3'd4, 32'd1000, 32'd7, 0, 0, 15);
    run_req(3'd4, 32'd100, 32'd7, 0, 0, 0);
    run_req(3'd6, 32'hFFFFFF9C, 32'd7, 0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      run_req(3'($urandom), rnd_operand(), rnd_operand(), 0, 0, 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
